level_debounce_sync: RTL and testbench

- Upstream conditioning stage for the level-to-pulse block: takes a raw asynchronous level and produces a clean, synchronised, debounced level in the clk domain.
- Also emits registered one-cycle rise/fall strobes.
- Chain: multi-flop synchroniser, then a debounce counter/FSM, then registered outputs. level_out feeds the downstream level-to-pulse block directly.

---
 rtl/cdc_pkg.sv | 20 ++
 rtl/sync_chain.sv | 26 ++
 rtl/level_debounce_sync.sv | 149 ++++++++++++++
 tb/tb_level_debounce_sync.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared CDC definitions: debounce FSM encoding, default depths and a saturating counter helper.
package cdc_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      PEND_HIGH   = 2'b01,
      STABLE_HIGH = 2'b11,
      PEND_LOW    = 2'b10
   } dbnc_state_e;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
   localparam int unsigned GLITCH_CNT_W        = 8;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [GLITCH_CNT_W-1:0] sat_inc(input logic [GLITCH_CNT_W-1:0] v);
      return (&v) ? v : v + GLITCH_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Parameterised N-flop level synchroniser with asynchronous active-low reset.
module sync_chain
   import cdc_pkg::*;
#(
   parameter int unsigned STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Pure shift chain: nothing may sit between the metastability-settling stages.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/level_debounce_sync.sv
// Synchronises and debounces a raw asynchronous level, with registered rise/fall strobes.
// Optional rejected-glitch counter enabled by LEVEL_DEBOUNCE_GLITCH_CNT_EN.
module level_debounce_sync
   import cdc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic d_async,
   output logic level_out,
   output logic rise,
   output logic fall
`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_CNT_W-1:0] glitch_cnt
`endif
);

   localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              d_sync;
   dbnc_state_e       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;

   sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_sync_chain (
      .clk (clk),
      .rst (rst),
      .d_i (d_async),
      .q_o (d_sync)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Level follows d_sync only after DEBOUNCE_CYCLES consecutive differing samples.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      unique case (state_q)
         STABLE_LOW: begin
            if (d_sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = STABLE_HIGH;
                  level_d = 1'b1;
                  rise_d  = 1'b1;
               end else begin
                  state_d = PEND_HIGH;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         PEND_HIGH: begin
            if (!d_sync) begin
               state_d = STABLE_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_HIGH;
               level_d = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STABLE_HIGH: begin
            if (!d_sync) begin
               if (DEBOUNCE_CYCLES == 1) begin
                  state_d = STABLE_LOW;
                  level_d = 1'b0;
                  fall_d  = 1'b1;
               end else begin
                  state_d = PEND_LOW;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         PEND_LOW: begin
            if (d_sync) begin
               state_d = STABLE_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = STABLE_LOW;
               level_d = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign level_out = level_q;
   assign rise      = rise_q;
   assign fall      = fall_q;

`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
   logic [GLITCH_CNT_W-1:0] glitch_q, glitch_d;

   // Count aborted pending transitions, saturating at all-ones.
   always_comb begin
      glitch_d = glitch_q;
      if (((state_q == PEND_HIGH) && !d_sync) || ((state_q == PEND_LOW) && d_sync)) begin
         glitch_d = sat_inc(glitch_q);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         glitch_q <= '0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`else
   // Without the counter, aborted transitions leave no trace.
`endif

endmodule

// File: tb/tb_level_debounce_sync.sv
// Directed self-checking bench: default instance plus a SYNC_STAGES=3, DEBOUNCE_CYCLES=1 instance.
// Glitch-counter checks compile in with LEVEL_DEBOUNCE_GLITCH_CNT_EN.
module tb_level_debounce_sync;

   logic       clk = 1'b0;
   logic       rst;
   logic       d_async;
   logic       level_out, rise, fall;
   logic       d1_async;
   logic       level1, rise1, fall1;
   logic [7:0] glitch_cnt, glitch1;

   int unsigned pass_cnt  = 0;
   int unsigned fail_cnt  = 0;
   int unsigned total_cnt = 0;

   always #5 clk = ~clk;

   level_debounce_sync dut (
      .clk       (clk),
      .rst       (rst),
      .d_async   (d_async),
      .level_out (level_out),
      .rise      (rise),
      .fall      (fall)
`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt)
`endif
   );

   level_debounce_sync #(
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .d_async   (d1_async),
      .level_out (level1),
      .rise      (rise1),
      .fall      (fall1)
`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch1)
`endif
   );

`ifndef LEVEL_DEBOUNCE_GLITCH_CNT_EN
   assign glitch_cnt = '0;
   assign glitch1    = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step n edges; from edge tgt onward level_out must be new_lvl, with its strobe on edge tgt only.
   task automatic watch(input string tag, input int n, input int tgt, input logic new_lvl);
      for (int k = 1; k <= n; k++) begin
         step();
         chk({tag, "_level"}, 32'(level_out), 32'((k >= tgt) ? new_lvl : !new_lvl));
         chk({tag, "_rise"},  32'(rise),      32'(new_lvl && (k == tgt)));
         chk({tag, "_fall"},  32'(fall),      32'(!new_lvl && (k == tgt)));
      end
   endtask

   task automatic chk_glitch(input string tag, input int exp);
`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
      chk(tag, 32'(glitch_cnt), 32'(exp));
`endif
   endtask

   initial begin
      rst      = 1'b0;
      d_async  = 1'b1;
      d1_async = 1'b0;
      #1;
      chk("rst0_level", 32'(level_out), 32'd0);
      chk("rst0_rise",  32'(rise),      32'd0);
      chk("rst0_fall",  32'(fall),      32'd0);
      chk_glitch("rst0_glitch", 0);
      watch("rsthold", 2, 99, 1'b1);
      chk_glitch("rsthold_glitch", 0);

      // Release with input already high: six-edge latency
      rst = 1'b1;
      watch("rel", 7, 6, 1'b1);

      d_async = 1'b0;
      watch("cfall", 10, 6, 1'b0);
      d_async = 1'b1;
      watch("crise", 10, 6, 1'b1);
      d_async = 1'b0;
      watch("cfall2", 10, 6, 1'b0);

      // Three-cycle pulse is rejected
      d_async = 1'b1;
      watch("g3a", 3, 99, 1'b1);
      d_async = 1'b0;
      watch("g3b", 8, 99, 1'b1);
      chk_glitch("g3_glitch", 1);

      // Four-cycle pulse is accepted, then released
      d_async = 1'b1;
      watch("p4a", 4, 99, 1'b1);
      d_async = 1'b0;
      watch("p4b", 5, 2, 1'b1);
      watch("p4c", 4, 1, 1'b0);
      chk_glitch("p4_glitch", 1);

      // Reset while pending high with cnt=2
      d_async = 1'b1;
      watch("mr", 4, 99, 1'b1);
      rst = 1'b0;
      #1;
      chk("mr_level", 32'(level_out), 32'd0);
      chk("mr_rise",  32'(rise),      32'd0);
      chk_glitch("mr_glitch", 0);
      watch("mrhold", 2, 99, 1'b1);
      rst = 1'b1;
      watch("mrrel", 7, 6, 1'b1);

      // Asynchronous reset away from the clock edge while high
      #2;
      rst = 1'b0;
      #1;
      chk("ar_level", 32'(level_out), 32'd0);
      chk("ar_fall",  32'(fall),      32'd0);
      step();
      rst     = 1'b1;
      d_async = 1'b0;
      watch("arrel", 10, 99, 1'b1);

      // SYNC_STAGES=3, DEBOUNCE_CYCLES=1: four-edge latency per toggle
      for (int t = 0; t < 8; t++) begin
         logic nl;
         nl       = ~d1_async;
         d1_async = nl;
         for (int k = 1; k <= 4; k++) begin
            step();
            chk("d1_level", 32'(level1), 32'((k == 4) ? nl : !nl));
            chk("d1_rise",  32'(rise1),  32'(nl && (k == 4)));
            chk("d1_fall",  32'(fall1),  32'(!nl && (k == 4)));
         end
      end
`ifdef LEVEL_DEBOUNCE_GLITCH_CNT_EN
      chk("d1_glitch", 32'(glitch1), 32'd0);
`endif

      // 300 two-cycle glitches: level stays low, counter saturates
      for (int g = 1; g <= 300; g++) begin
         d_async = 1'b1;
         step();
         step();
         d_async = 1'b0;
         for (int k = 0; k < 4; k++) step();
         chk("sat_level", 32'(level_out), 32'd0);
         if (g == 100) chk_glitch("sat_100", 100);
         if (g == 255) chk_glitch("sat_255", 255);
      end
      chk_glitch("sat_300", 255);
      chk("sat_rise", 32'(rise), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
